// File: rtl/alu_decode_if.sv
// Fetch-side and execute-side handshake bundle for alu_decode, including the ALU
// comparison feedback used for branch resolution.
interface alu_decode_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_insn;
    logic [WIDTH-1:0] in_pc;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [2:0]       out_op;
    logic             out_sub_enable;
    logic             out_arith_shift;
    logic [4:0]       out_shamt;
    logic             out_use_imm;
    logic [WIDTH-1:0] out_imm;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [4:0]       out_rd;
    logic [2:0]       out_kind;
    logic             out_illegal;

    logic             br_eq;
    logic             br_bge;
    logic             br_bgeu;
    logic             br_taken;

    modport master (
        output in_valid, in_insn, in_pc, out_ready, br_eq, br_bge, br_bgeu,
        input  in_ready, out_valid, out_pc, out_op, out_sub_enable, out_arith_shift,
               out_shamt, out_use_imm, out_imm, out_rs1, out_rs2, out_rd, out_kind,
               out_illegal, br_taken
    );

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready, br_eq, br_bge, br_bgeu,
        output in_ready, out_valid, out_pc, out_op, out_sub_enable, out_arith_shift,
               out_shamt, out_use_imm, out_imm, out_rs1, out_rs2, out_rd, out_kind,
               out_illegal, br_taken
    );
endinterface

// File: rtl/alu_decode.sv
// RV32I decode/issue stage with a 2-entry skid buffer and branch resolution.
// Define YARI_ILLEGAL_INSN_EN to enable illegal-encoding detection (out_illegal).
module alu_decode #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    input logic         flush,
    alu_decode_if.slave bus
);
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    localparam logic [2:0] KindAlu    = 3'd0;
    localparam logic [2:0] KindBranch = 3'd1;
    localparam logic [2:0] KindLoad   = 3'd2;
    localparam logic [2:0] KindStore  = 3'd3;
    localparam logic [2:0] KindJal    = 3'd4;
    localparam logic [2:0] KindJalr   = 3'd5;
    localparam logic [2:0] KindLui    = 3'd6;
    localparam logic [2:0] KindAuipc  = 3'd7;

    localparam logic [2:0] AluAdd = 3'b000;

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [2:0]       op;
        logic             sub_enable;
        logic             arith_shift;
        logic [4:0]       shamt;
        logic             use_imm;
        logic [WIDTH-1:0] imm;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic [2:0]       kind;
        logic             illegal;
        logic [2:0]       funct3;
    } entry_t;

    logic [31:0] insn;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign insn   = bus.in_insn;
    assign opcode = insn[6:0];
    assign funct3 = insn[14:12];
    assign imm_i  = {{20{insn[31]}}, insn[31:20]};
    assign imm_s  = {{20{insn[31]}}, insn[31:25], insn[11:7]};
    assign imm_b  = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    assign imm_j  = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    assign imm_u  = {insn[31:12], 12'b0};

`ifdef YARI_ILLEGAL_INSN_EN
    logic [6:0] funct7;
    logic       op_funct7_bad;
    logic       shift_funct7_bad;

    assign funct7 = insn[31:25];
    // 0100000 is only meaningful for SUB and SRA.
    assign op_funct7_bad = !((funct7 == 7'b0000000) ||
                             ((funct7 == 7'b0100000) &&
                              ((funct3 == 3'b000) || (funct3 == 3'b101))));
    assign shift_funct7_bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                              ((funct3 == 3'b101) && (funct7 != 7'b0000000) &&
                               (funct7 != 7'b0100000));
`endif

    entry_t dec;
    logic   nop;

    always_comb begin
        dec        = '0;
        nop        = 1'b0;
        dec.pc     = bus.in_pc;
        dec.funct3 = funct3;
        dec.shamt  = insn[24:20];
        dec.rs1    = insn[19:15];
        dec.rs2    = insn[24:20];
        dec.rd     = insn[11:7];
        dec.op     = AluAdd;
        dec.kind   = KindAlu;

        case (opcode)
            OpcOp: begin
                dec.op          = funct3;
                dec.sub_enable  = (insn[30] && (funct3 == 3'b000)) ||
                                  (funct3 == 3'b010) || (funct3 == 3'b011);
                dec.arith_shift = insn[30] && (funct3 == 3'b101);
`ifdef YARI_ILLEGAL_INSN_EN
                nop = op_funct7_bad;
`endif
            end
            OpcOpImm: begin
                dec.op          = funct3;
                dec.sub_enable  = (funct3 == 3'b010) || (funct3 == 3'b011);
                dec.arith_shift = insn[30] && (funct3 == 3'b101);
                dec.use_imm     = 1'b1;
                dec.imm         = WIDTH'($signed(imm_i));
`ifdef YARI_ILLEGAL_INSN_EN
                nop = shift_funct7_bad;
`endif
            end
            OpcBranch: begin
                dec.sub_enable = 1'b1;
                dec.kind       = KindBranch;
                dec.imm        = WIDTH'($signed(imm_b));
                dec.rd         = 5'd0;
            end
            OpcLoad: begin
                dec.use_imm = 1'b1;
                dec.kind    = KindLoad;
                dec.imm     = WIDTH'($signed(imm_i));
            end
            OpcStore: begin
                dec.use_imm = 1'b1;
                dec.kind    = KindStore;
                dec.imm     = WIDTH'($signed(imm_s));
                dec.rd      = 5'd0;
            end
            OpcJal: begin
                dec.use_imm = 1'b1;
                dec.kind    = KindJal;
                dec.imm     = WIDTH'($signed(imm_j));
            end
            OpcJalr: begin
                dec.use_imm = 1'b1;
                dec.kind    = KindJalr;
                dec.imm     = WIDTH'($signed(imm_i));
            end
            OpcLui: begin
                dec.use_imm = 1'b1;
                dec.kind    = KindLui;
                dec.imm     = WIDTH'($signed(imm_u));
            end
            OpcAuipc: begin
                dec.use_imm = 1'b1;
                dec.kind    = KindAuipc;
                dec.imm     = WIDTH'($signed(imm_u));
            end
            default: nop = 1'b1;
        endcase

        // Unrecognised encodings retire as a harmless ALU add writing x0.
        if (nop) begin
            dec.op          = AluAdd;
            dec.sub_enable  = 1'b0;
            dec.arith_shift = 1'b0;
            dec.use_imm     = 1'b0;
            dec.imm         = '0;
            dec.kind        = KindAlu;
            dec.rd          = 5'd0;
        end
`ifdef YARI_ILLEGAL_INSN_EN
        dec.illegal = nop;
`else
        dec.illegal = 1'b0;
`endif
    end

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_full_q, skid_full_d;
    logic   accept;
    logic   consume;

    assign accept  = bus.in_valid && !skid_full_q;
    assign consume = out_valid_q && bus.out_ready;

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;

        if (!out_valid_q || consume) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = accept;
                if (accept) begin
                    skid_d = dec;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_d = dec;
                end
            end
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign bus.in_ready        = !skid_full_q;
    assign bus.out_valid       = out_valid_q;
    assign bus.out_pc          = out_q.pc;
    assign bus.out_op          = out_q.op;
    assign bus.out_sub_enable  = out_q.sub_enable;
    assign bus.out_arith_shift = out_q.arith_shift;
    assign bus.out_shamt       = out_q.shamt;
    assign bus.out_use_imm     = out_q.use_imm;
    assign bus.out_imm         = out_q.imm;
    assign bus.out_rs1         = out_q.rs1;
    assign bus.out_rs2         = out_q.rs2;
    assign bus.out_rd          = out_q.rd;
    assign bus.out_kind        = out_q.kind;
    assign bus.out_illegal     = out_q.illegal;

    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        case (out_q.funct3)
            3'b000:  br_cond = bus.br_eq;
            3'b001:  br_cond = !bus.br_eq;
            3'b100:  br_cond = !bus.br_bge;
            3'b101:  br_cond = bus.br_bge;
            3'b110:  br_cond = !bus.br_bgeu;
            3'b111:  br_cond = bus.br_bgeu;
            default: br_cond = 1'b0;
        endcase
    end

    assign bus.br_taken = out_valid_q && (out_q.kind == KindBranch) && br_cond;
endmodule

// File: tb/tb_alu_decode.sv
// Randomized self-checking bench for alu_decode against a queue-based reference model.
module tb_alu_decode;
`ifdef YARI_ILLEGAL_INSN_EN
    localparam bit IllegalEn = 1'b1;
`else
    localparam bit IllegalEn = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  op;
        logic        sub_enable;
        logic        arith_shift;
        logic [4:0]  shamt;
        logic        use_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  kind;
        logic        illegal;
        logic [2:0]  f3;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    bit   run_checks = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t model_q[$];

    alu_decode_if #(.WIDTH(32)) bus ();

    alu_decode #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] insn, input logic [31:0] pc);
        exp_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         nop;
        f3  = insn[14:12];
        f7  = insn[31:25];
        nop = 1'b0;
        e       = '0;
        e.pc    = pc;
        e.f3    = f3;
        e.shamt = insn[24:20];
        e.rs1   = insn[19:15];
        e.rs2   = insn[24:20];
        e.rd    = insn[11:7];
        case (insn[6:0])
            7'h33: begin
                e.op          = f3;
                e.sub_enable  = (f3 == 0 && insn[30]) || f3 == 2 || f3 == 3;
                e.arith_shift = insn[30] && f3 == 5;
                if (IllegalEn && !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)))) nop = 1;
            end
            7'h13: begin
                e.op          = f3;
                e.sub_enable  = f3 == 2 || f3 == 3;
                e.arith_shift = insn[30] && f3 == 5;
                e.use_imm     = 1;
                e.imm         = 32'($signed(insn) >>> 20);
                if (IllegalEn && f3 == 1 && f7 != 0) nop = 1;
                if (IllegalEn && f3 == 5 && f7 != 0 && f7 != 7'h20) nop = 1;
            end
            7'h63: begin
                e.kind = 1; e.sub_enable = 1; e.rd = 0;
                e.imm = 32'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 20'b0}) >>> 19);
            end
            7'h03: begin e.kind = 2; e.use_imm = 1; e.imm = 32'($signed(insn) >>> 20); end
            7'h23: begin
                e.kind = 3; e.use_imm = 1; e.rd = 0;
                e.imm = 32'($signed({insn[31:25], insn[11:7], 20'b0}) >>> 20);
            end
            7'h6F: begin
                e.kind = 4; e.use_imm = 1;
                e.imm = 32'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 12'b0}) >>> 11);
            end
            7'h67: begin e.kind = 5; e.use_imm = 1; e.imm = 32'($signed(insn) >>> 20); end
            7'h37: begin e.kind = 6; e.use_imm = 1; e.imm = {insn[31:12], 12'b0}; end
            7'h17: begin e.kind = 7; e.use_imm = 1; e.imm = {insn[31:12], 12'b0}; end
            default: nop = 1;
        endcase
        if (nop) begin
            e.op = 0; e.sub_enable = 0; e.arith_shift = 0; e.use_imm = 0;
            e.imm = 0; e.kind = 0; e.rd = 0; e.illegal = IllegalEn;
        end
        return e;
    endfunction

    function automatic bit ref_taken(input exp_t e);
        bit c;
        case (e.f3)
            0: c = bus.br_eq;
            1: c = !bus.br_eq;
            4: c = !bus.br_bge;
            5: c = bus.br_bge;
            6: c = !bus.br_bgeu;
            7: c = bus.br_bgeu;
            default: c = 0;
        endcase
        return (e.kind == 1) && c;
    endfunction

    function automatic logic [127:0] pack_exp(input exp_t e);
        return {34'b0, e.pc, e.op, e.sub_enable, e.arith_shift, e.shamt, e.use_imm, e.imm,
                e.rs1, e.rs2, e.rd, e.kind, e.illegal};
    endfunction

    function automatic logic [127:0] pack_act();
        return {34'b0, bus.out_pc, bus.out_op, bus.out_sub_enable, bus.out_arith_shift,
                bus.out_shamt, bus.out_use_imm, bus.out_imm, bus.out_rs1, bus.out_rs2,
                bus.out_rd, bus.out_kind, bus.out_illegal};
    endfunction

    // Reference buffer: occupancy 2 means the skid is full.
    task automatic model_step();
        bit acc;
        bit con;
        acc = bus.in_valid && (model_q.size() < 2);
        con = bus.out_ready && (model_q.size() > 0);
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (con) void'(model_q.pop_front());
            if (acc) model_q.push_back(ref_decode(bus.in_insn, bus.in_pc));
        end
    endtask

    always @(negedge clk) begin
        if (run_checks) begin
            check("in_ready", 128'(bus.in_ready), 128'(model_q.size() < 2));
            check("out_valid", 128'(bus.out_valid), 128'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                check("payload", pack_act(), pack_exp(model_q[0]));
                check("br_taken", 128'(bus.br_taken), 128'(ref_taken(model_q[0])));
            end else begin
                check("br_taken_idle", 128'(bus.br_taken), 128'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic offer(input bit v, input logic [31:0] insn, input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_insn  = insn;
        bus.in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0]  opcs [9];
        logic [31:0] w;
        int          pick;
        int          r;
        opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h37, 7'h17};
        w    = $urandom();
        pick = $urandom_range(0, 10);
        if (pick < 9) w[6:0] = opcs[pick];
        if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
            r = $urandom_range(0, 9);
            if (r < 6) w[31:25] = 7'h00;
            else if (r < 9) w[31:25] = 7'h20;
        end
        return w;
    endfunction

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.br_eq = 1'b0;
        bus.br_bge = 1'b0;
        bus.br_bgeu = 1'b0;
        offer(1'b1, 32'h002081B3, 32'h40);
        tick();
        run_checks = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check("rst_payload", pack_act(), 128'(0));
        check("rst_br_taken", 128'(bus.br_taken), 128'(0));

        bus.out_ready = 1'b1;
        offer(1'b1, 32'h002081B3, 32'h100);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("add_valid", 128'(bus.out_valid), 128'(1));
        check("add_fields", {bus.out_op, bus.out_sub_enable, bus.out_rs1, bus.out_rs2,
                             bus.out_rd, bus.out_use_imm, bus.out_kind},
              {3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 3'd0});

        offer(1'b1, 32'h40735293, 32'h104);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("srai_fields", {bus.out_op, bus.out_arith_shift, bus.out_shamt, bus.out_use_imm,
                              bus.out_rs1, bus.out_rd, bus.out_sub_enable},
              {3'd5, 1'b1, 5'd7, 1'b1, 5'd6, 5'd5, 1'b0});

        offer(1'b1, 32'hFE20CEE3, 32'h108);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("blt_fields", {bus.out_kind, bus.out_imm, bus.out_sub_enable},
              {3'd1, 32'hFFFFFFFC, 1'b1});
        bus.br_bge = 1'b0;
        #1;
        check("blt_taken", 128'(bus.br_taken), 128'(1));
        bus.br_bge = 1'b1;
        #1;
        check("blt_not_taken", 128'(bus.br_taken), 128'(0));
        tick();

        // Backpressure: A held, B in skid, C stalled until space frees.
        bus.out_ready = 1'b0;
        offer(1'b1, 32'h00A00093, 32'h200);
        tick();
        check("bp_a_out", 128'(bus.out_pc), 128'(32'h200));
        offer(1'b1, 32'h00B00113, 32'h204);
        tick();
        check("bp_skid_ready", 128'(bus.in_ready), 128'(0));
        offer(1'b1, 32'h00C00193, 32'h208);
        tick();
        tick();
        check("bp_a_hold", 128'(bus.out_pc), 128'(32'h200));
        bus.out_ready = 1'b1;
        tick();
        check("bp_b_out", {bus.out_valid, bus.out_pc, bus.in_ready}, {1'b1, 32'h204, 1'b1});
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("bp_c_out", {bus.out_valid, bus.out_pc}, {1'b1, 32'h208});
        tick();
        check("bp_drained", 128'(bus.out_valid), 128'(0));

        bus.out_ready = 1'b0;
        offer(1'b1, 32'h00100213, 32'h300);
        tick();
        offer(1'b1, 32'h00200293, 32'h304);
        tick();
        offer(1'b1, 32'h00300313, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("flush_full", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});
        bus.out_ready = 1'b1;
        tick();
        check("flush_full_gone", 128'(bus.out_valid), 128'(0));

        bus.out_ready = 1'b0;
        offer(1'b1, 32'h00400393, 32'h400);
        tick();
        offer(1'b1, 32'h00500413, 32'h404);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check("flush_in_xfer", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});
        tick();
        check("flush_in_gone", 128'(bus.out_valid), 128'(0));

        bus.out_ready = 1'b1;
        offer(1'b1, 32'h00000000, 32'h500);
        tick();
        offer(1'b0, 32'h0, 32'h0);
        check("zero_insn", {bus.out_valid, bus.out_illegal, bus.out_rd, bus.out_kind, bus.out_op},
              {1'b1, IllegalEn, 5'd0, 3'd0, 3'd0});
        tick();

        for (int i = 0; i < 4000; i++) begin
            reset         = ($urandom_range(0, 199) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.br_eq     = $urandom_range(0, 1) != 0;
            bus.br_bge    = $urandom_range(0, 1) != 0;
            bus.br_bgeu   = $urandom_range(0, 1) != 0;
            offer($urandom_range(0, 9) < 7, rand_insn(), $urandom());
            tick();
        end

        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        offer(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        tick();
        run_checks = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_decode.md
# alu_decode

Decode/issue stage that turns RV32I instruction words into the control and operand-select fields consumed by the `alu` block (op, sub_enable, arith_shift, shamt), plus immediate, register indices and instruction kind. It also closes the loop on the ALU's comparison outputs by resolving branch direction from eq/bge/bgeu. It sits between fetch and execute with a valid/ready handshake on both sides and a 2-entry skid buffer, so it sustains one instruction per cycle under backpressure.

## Interface

Parameters:
- WIDTH, 32, datapath and PC width; instruction word is always 32 bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  discard all held instructions (synchronous).
- in_valid  in  1  fetch offers in_insn/in_pc.
- in_ready  out  1  decoder accepts; transfer when in_valid & in_ready.
- in_insn  in  32  instruction word.
- in_pc  in  WIDTH  instruction address.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute consumes; transfer when out_valid & out_ready.
- out_pc  out  WIDTH  PC of decoded instruction.
- out_op  out  3  ALU op code (ADD 000, SL 001, SLT 010, SLTU 011, XOR 100, SR 101, OR 110, AND 111).
- out_sub_enable  out  1  ALU subtract.
- out_arith_shift  out  1  ALU arithmetic right shift.
- out_shamt  out  5  immediate shift amount (insn[24:20]).
- out_use_imm  out  1  ALU b operand is out_imm and shamt is out_shamt; else b = rs2 value, shamt = rs2[4:0].
- out_imm  out  WIDTH  sign-extended immediate for the kind.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_kind  out  3  0 ALU, 1 BRANCH, 2 LOAD, 3 STORE, 4 JAL, 5 JALR, 6 LUI, 7 AUIPC.
- out_illegal  out  1  illegal encoding (see Configuration).
- br_eq, br_bge, br_bgeu  in  1 each  ALU comparison results for the current output instruction.
- br_taken  out  1  branch resolution.

## Operation

- Decode is pure function of in_insn; result registered into output entry or skid entry.
- OP (0110011): out_op = funct3; sub_enable = insn[30] & funct3==000, or funct3 in {010,011}; arith_shift = insn[30] & funct3==101; use_imm=0; kind ALU.
- OP-IMM (0010011): out_op = funct3; sub_enable = 1 only for funct3 010/011; arith_shift = insn[30] & funct3==101; use_imm=1; imm = I-imm.
- BRANCH (1100011): op ADD, sub_enable=1, use_imm=0, kind BRANCH, imm = B-imm, rd forced 0.
- LOAD/STORE/JAL/JALR/LUI/AUIPC: op ADD, sub_enable=0, use_imm=1, imm = I/S/J/I/U/U form; STORE rd forced 0.
- Fields not used by a kind (rs1/rs2) still carry raw insn bits; consumers ignore them.
- br_taken = out_valid & kind==BRANCH & cond(funct3): 000 eq, 001 !eq, 100 !bge, 101 bge, 110 !bgeu, 111 bgeu, 010/011 -> 0. Combinational from held funct3 and br_* inputs.
- Buffering: output entry (out_valid) + skid entry (skid_full). in_ready = !skid_full (register-driven, no combinational path from out_ready).
  - Accept while output empty or consumed same cycle -> decode into output entry.
  - Accept while output held (out_valid & !out_ready) -> decode into skid, skid_full=1.
  - Consume with skid_full -> skid moves to output, skid_full=0; a simultaneous accept writes the skid again.
  - Order strictly preserved; no drops or duplicates.
- flush: next cycle out_valid=0, skid_full=0; input transfer in the flush cycle is discarded. flush has priority over all handshake events.

## Timing

- Latency: accept in cycle N -> out_valid with that instruction in N+1.
- Throughput: 1/cycle with out_ready held high.
- in_ready deasserts the cycle after a skid write; reasserts the cycle after skid drains.
- Reset: out_valid=0, skid_full=0, in_ready=1 after reset; all payload outputs 0 (out_kind ALU, out_illegal 0, br_taken 0). Transfers offered during reset are discarded. Reset mid-stream drops both entries.

## Configuration

- YARI_ILLEGAL_INSN_EN defined: insn[1:0]!=11, unknown opcode, OP with funct7 not 0000000/0100000 (or 0100000 on funct3 other than 000/101), or OP-IMM shift with bad insn[31:25] -> out_illegal=1, kind ALU, op ADD, rd=0.
- Undefined: out_illegal tied 0; same encodings decode as NOP (kind ALU, op ADD, rd=0), no detection logic.

## Test plan

- 0x002081B3 (add x3,x1,x2), out_ready=1 -> next cycle out_valid=1, op 000, sub 0, rs1 1, rs2 2, rd 3, use_imm 0, kind ALU.
- 0x40735293 (srai x5,x6,7) -> op 101, arith_shift 1, shamt 7, use_imm 1, rs1 6, rd 5, sub 0.
- 0xFE20CEE3 (blt x1,x2,-4) -> kind BRANCH, imm 0xFFFFFFFC, sub 1; br_bge=0 -> br_taken=1; br_bge=1 -> 0.
- out_ready=0, three back-to-back valid insns A,B,C -> A held on output, B in skid, in_ready=0 from cycle after B, C not accepted; out_ready=1 -> A, B, C emitted in order, none duplicated.
- Both entries full, flush=1 one cycle -> next cycle out_valid=0, in_ready=1; earlier instructions never appear.
- 0x00000000 with YARI_ILLEGAL_INSN_EN -> out_illegal=1, rd 0; without -> out_illegal=0, kind ALU, op ADD, rd 0.
